instr_sequencer: RTL

Instruction sequencer for the 8-bit processor. It generates the fixed four-phase instruction cycle: FETCH, DECODE, EXEC, UPDATE. It also drives the program counter's `load`/`inc` strobes and the instruction-register load, handles memory wait states, and implements halt and fetch-timeout fault handling. It sits between the instruction memory, the instruction decoder and the PC, replacing the PC's private phase counter as the single source of instruction timing.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/instr_sequencer_if.sv | 27 ++
 rtl/instr_sequencer_fetch_watchdog.sv | 42 ++++
 rtl/instr_sequencer.sv | 92 +++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer: state encoding, the
// latched instruction class bundle and the default parameter values.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_UPDATE = 3'd4,
        ST_HALT   = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    typedef struct packed {
        logic jump;
        logic branch_z;
        logic halt;
    } iclass_t;

    localparam int unsigned TIMEOUT_DEFAULT = 16;
    localparam int unsigned CNT_W_DEFAULT   = 16;

endpackage

// File: rtl/instr_sequencer_if.sv
// Memory, decoder, datapath and PC strobe signals that the sequencer
// exchanges with the rest of the processor.
interface instr_sequencer_if;

    logic mem_rd;
    logic mem_ready;
    logic ir_load;
    logic is_jump;
    logic is_branch_z;
    logic is_halt;
    logic z_flag;
    logic exec_stall;
    logic exec_en;
    logic pc_inc;
    logic pc_load;

    modport master (
        output mem_rd, ir_load, exec_en, pc_inc, pc_load,
        input  mem_ready, is_jump, is_branch_z, is_halt, z_flag, exec_stall
    );

    modport slave (
        input  mem_rd, ir_load, exec_en, pc_inc, pc_load,
        output mem_ready, is_jump, is_branch_z, is_halt, z_flag, exec_stall
    );

endinterface

// File: rtl/instr_sequencer_fetch_watchdog.sv
// Counts consecutive FETCH cycles without memory data and flags the
// TIMEOUT-th such cycle. TIMEOUT of 0 disables the watchdog.
module fetch_watchdog
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic cnt_en,
    output logic expired
);

    localparam int unsigned W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // The counter holds the number of prior waits, so LAST marks the TIMEOUT-th wait.
    always_comb begin
        expired = (TIMEOUT != 0) && cnt_en && !clr && (cnt_q == LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Four-phase instruction sequencer (FETCH, DECODE, EXEC, UPDATE) driving the
// IR load, execute enable and PC strobes, with halt and fetch-timeout fault.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    instr_sequencer_if.master  bus,
    output logic [2:0]         state,
    output logic               busy,
    output logic               halted,
    output logic               fault,
    output logic [CNT_W-1:0]   instr_count
);

    state_t           state_q, state_d;
    iclass_t          cls_q, cls_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wd_expired;
    logic             take_load;

    fetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_q != ST_FETCH),
        .cnt_en  ((state_q == ST_FETCH) && !bus.mem_ready),
        .expired (wd_expired)
    );

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_FETCH;
            ST_FETCH: begin
                if (bus.mem_ready) begin
                    state_d = ST_DECODE;
                end else if (wd_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DECODE: begin
                cls_d   = '{jump: bus.is_jump, branch_z: bus.is_branch_z, halt: bus.is_halt};
                state_d = ST_EXEC;
            end
            ST_EXEC:   if (!bus.exec_stall) state_d = ST_UPDATE;
            ST_UPDATE: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = cls_q.halt ? ST_HALT : ST_FETCH;
            end
            ST_HALT:   if (start) state_d = ST_FETCH;
            ST_FAULT:  state_d = ST_FAULT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // PC strobes are gated by reset so an UPDATE cut short by reset leaves the PC untouched.
    always_comb begin
        take_load   = cls_q.jump || (cls_q.branch_z && bus.z_flag);
        bus.mem_rd  = (state_q == ST_FETCH);
        bus.ir_load = (state_q == ST_FETCH) && bus.mem_ready;
        bus.exec_en = (state_q == ST_EXEC);
        bus.pc_load = (state_q == ST_UPDATE) && !cls_q.halt && take_load && !reset;
        bus.pc_inc  = (state_q == ST_UPDATE) && !cls_q.halt && !take_load && !reset;
        state       = state_q;
        busy        = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                      (state_q == ST_EXEC)  || (state_q == ST_UPDATE);
        halted      = (state_q == ST_HALT);
        fault       = (state_q == ST_FAULT);
        instr_count = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cls_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
